lpn_session_sequencer: RTL
==========================

Name: lpn_session_sequencer

Overview:
Control-plane sequencer placed in front of the LPN-PUF `system` core.
- Starts a generation (mode=0) or verification (mode=1) session on a rising edge of `global_start`.
- Pulses the PoK reset and waits for `pok_done`.
- Gates the 128-bit input AXI-stream into fixed-length frames, phase by phase, enforcing frame length and frame count.
- Reports phase, progress, completion and protocol errors.
- Data bits pass outside this block; it handles only the valid/ready/last handshake.

Parameters:
- BEATS_PER_FRAME, 4, beats per frame; TLAST is required on the last beat.
- GEN_A_FRAMES, 113, frames of A in generation.
- VER_AINV_FRAMES, 32, frames of A-inverse in verification.
- VER_A_FRAMES, 113, frames of A in verification.
- POK_RST_CYCLES, 4, cycles `pok_resetn` is held low.
- POK_TIMEOUT, 1023, maximum cycles to wait for `pok_done`.

Ports:
- clk  in  1  single clock
- resetn  in  1  asynchronous active-low reset
- mode  in  1  0=gen, 1=ver; sampled on the start edge
- global_start  in  1  session request; level input, rising-edge triggered
- pok_done  in  1  PoK response valid
- pok_resetn  out  1  active-low PoK reset
- fault  in  1  fault flag from the core
- up_tvalid  in  1  host stream valid
- up_tlast  in  1  host stream last
- up_tready  out  1  host stream ready
- dn_tvalid  out  1  gated valid to the core (data_in_TVALID)
- dn_tlast  out  1  gated last to the core
- dn_tready  in  1  core ready (data_in_TREADY)
- phase  out  3  current phase code
- frame_cnt  out  7  frames completed in the current phase
- busy  out  1  session in progress
- done  out  1  session completed
- err  out  1  sticky error
- err_code  out  3  cause of the error

Behaviour:
- Reset values: `pok_resetn`=1, `up_tready`=0, `dn_tvalid`=0, `dn_tlast`=0, `phase`=PH_IDLE, `frame_cnt`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0. All counters are 0.
- Gating: `accept` = state is a stream phase.
  - `up_tready` = `accept` & `dn_tready`
  - `dn_tvalid` = `accept` & `up_tvalid`
  - `dn_tlast` = `accept` & `up_tlast`
  - These are combinational: zero added latency, no buffering.
  - Handshake `hs` = `up_tvalid` & `up_tready`.
- States: IDLE, POK_RST, POK_WAIT, S_I, S_B, S_AINV, S_A, S_HASH, DONE, ERROR.
- IDLE:
  - Rising edge of `global_start` (registered previous value) -> POK_RST on the next cycle.
  - `mode` is latched into `mode_q` at that edge; later changes to `mode` are ignored.
  - `busy`=1 from POK_RST until DONE or ERROR.
- POK_RST: `pok_resetn`=0 for exactly POK_RST_CYCLES cycles, then POK_WAIT.
- POK_WAIT:
  - `pok_done`=1 -> S_A if `mode_q`=0, else S_I.
  - `POK_TIMEOUT` cycles without `pok_done` -> ERROR with E_POK_TO.
- Phase sequence:
  - gen: S_A (GEN_A_FRAMES frames).
  - ver: S_I (1) -> S_B (1) -> S_AINV (VER_AINV_FRAMES) -> S_A (VER_A_FRAMES) -> S_HASH (1).
- Beat counting:
  - `beat_cnt` increments on each `hs`.
  - On `hs` with `beat_cnt`=BEATS_PER_FRAME-1:
    - `up_tlast` must be 1, else ERROR with E_LONG.
    - `beat_cnt` wraps to 0 and `frame_cnt` increments.
  - On `hs` with `up_tlast`=1 and `beat_cnt`<BEATS_PER_FRAME-1 -> ERROR with E_SHORT.
  - An erroring beat is still forwarded; the error registers on the next cycle.
- Phase advance:
  - The handshake that completes the phase's last frame advances to the next phase on the next cycle.
  - `frame_cnt` and `beat_cnt` clear to 0 on the phase change.
  - Backpressure (`dn_tready`=0) stalls counting without error.
- DONE: `done`=1 and `busy`=0. Stays in DONE until `global_start`=0 -> IDLE, where `done` clears.
- ERROR:
  - `err`=1 and `err_code` hold; `accept`=0.
  - Leaves to IDLE only when `global_start`=0; `err` and `err_code` clear on a new start edge.
- `fault`=1 in any state other than IDLE/DONE/ERROR -> ERROR with E_FAULT.
- Simultaneous events, in priority order: E_FAULT > frame errors > phase advance.
- `resetn` low mid-session: immediate return to all reset values.
- `global_start` held high across DONE or ERROR does not retrigger a session; a new rising edge is required.

Decomposition:
- Package `lpn_seq_pkg` holds:
  - phase codes: PH_IDLE=0, PH_POK=1, PH_I=2, PH_B=3, PH_AINV=4, PH_A=5, PH_HASH=6, PH_DONE=7. POK_RST and POK_WAIT both report PH_POK. ERROR keeps the phase code it faulted in.
  - error codes: E_NONE=0, E_SHORT=1, E_LONG=2, E_POK_TO=3, E_FAULT=4.
  - the per-phase frame-limit function.
- One sub-module, `frame_counter`: beat/frame counter with length check, instantiated once. It outputs `frame_done`, `phase_done`, `short_err` and `long_err`.

Test Plan:
- Gen happy path: mode=0, start pulse, `pok_done` after 20 cycles, 113 frames of 4 beats -> `pok_resetn` low for exactly 4 cycles; phase goes 1 -> 5 -> 7; `done`=1 one cycle after the 452nd handshake; `err`=0.
- Ver happy path: mode=1; send 1+1+32+113+1 frames -> phase sequence 2,3,4,5,6,7; `frame_cnt` reads 31 before the last AINV frame and resets to 0 at entry to S_A.
- Short frame: TLAST on beat 2 of the first S_A frame -> `err`=1, `err_code`=1, `up_tready`=0 from the next cycle; `global_start` low -> IDLE.
- PoK timeout: `pok_done` never asserted -> `err_code`=3 exactly 1023 cycles after entering POK_WAIT.
- Backpressure and fault: `dn_tready` toggled 50% during S_AINV -> correct counts, no error. Then `fault`=1 together with a TLAST-less final beat -> `err_code`=4.
- Reset mid-op: `resetn` low during S_A frame 40 -> all outputs at reset values; a new start edge gives a clean session with `frame_cnt`=0.

Source files
------------

// File: rtl/lpn_seq_pkg.sv
// Shared constants, phase/error/state codes and per-phase frame limits
// for the LPN-PUF session sequencer.
package lpn_seq_pkg;

    localparam int BEATS_PER_FRAME = 4;
    localparam int GEN_A_FRAMES    = 113;
    localparam int VER_AINV_FRAMES = 32;
    localparam int VER_A_FRAMES    = 113;
    localparam int POK_RST_CYCLES  = 4;
    localparam int POK_TIMEOUT     = 1023;

    localparam int BEAT_W    = $clog2(BEATS_PER_FRAME);
    localparam int FRAME_W   = 7;
    localparam int POK_RST_W = $clog2(POK_RST_CYCLES);
    localparam int POK_TO_W  = $clog2(POK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_POK  = 3'd1,
        PH_I    = 3'd2,
        PH_B    = 3'd3,
        PH_AINV = 3'd4,
        PH_A    = 3'd5,
        PH_HASH = 3'd6,
        PH_DONE = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        E_NONE   = 3'd0,
        E_SHORT  = 3'd1,
        E_LONG   = 3'd2,
        E_POK_TO = 3'd3,
        E_FAULT  = 3'd4
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_POK_RST  = 4'd1,
        ST_POK_WAIT = 4'd2,
        ST_I        = 4'd3,
        ST_B        = 4'd4,
        ST_AINV     = 4'd5,
        ST_A        = 4'd6,
        ST_HASH     = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } seq_state_e;

    // Number of frames the host must deliver in a given stream phase.
    // The A phase length depends on whether this is a verification session.
    function automatic logic [FRAME_W-1:0] frame_limit(input phase_e ph, input logic ver);
        logic [FRAME_W-1:0] lim;
        lim = FRAME_W'(1);
        case (ph)
            PH_AINV: lim = FRAME_W'(VER_AINV_FRAMES);
            PH_A:    lim = ver ? FRAME_W'(VER_A_FRAMES) : FRAME_W'(GEN_A_FRAMES);
            default: lim = FRAME_W'(1);
        endcase
        return lim;
    endfunction

    // Phase code reported for a state. ERROR is never passed here: the
    // sequencer keeps the code of the phase it faulted in.
    function automatic phase_e phase_of(input seq_state_e s);
        phase_e ph;
        ph = PH_IDLE;
        case (s)
            ST_POK_RST, ST_POK_WAIT: ph = PH_POK;
            ST_I:                    ph = PH_I;
            ST_B:                    ph = PH_B;
            ST_AINV:                 ph = PH_AINV;
            ST_A:                    ph = PH_A;
            ST_HASH:                 ph = PH_HASH;
            ST_DONE:                 ph = PH_DONE;
            default:                 ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/lpn_session_sequencer_frame_counter.sv
// Beat/frame counter for one stream phase. Flags frame completion,
// phase completion and frames that end too early or too late.
module frame_counter
    import lpn_seq_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               hs,
    input  logic               last,
    input  logic [FRAME_W-1:0] limit,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               frame_done,
    output logic               phase_done,
    output logic               short_err,
    output logic               long_err
);

    logic [BEAT_W-1:0] beat_cnt;
    logic              last_beat;

    assign last_beat = (beat_cnt == BEAT_W'(BEATS_PER_FRAME - 1));

    // Frame boundary and length checks, all qualified by a handshake.
    always_comb begin
        frame_done = hs & last_beat;
        phase_done = frame_done & (frame_cnt == (limit - FRAME_W'(1)));
        short_err  = hs & last & ~last_beat;
        long_err   = hs & last_beat & ~last;
    end

    // Count beats within a frame and frames within the phase; a phase
    // change clears both, even if it coincides with a handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (clear) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (hs) begin
            if (last_beat) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end else begin
                beat_cnt  <= beat_cnt + BEAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lpn_session_sequencer.sv
// Session sequencer in front of the LPN-PUF core: PoK reset/wait, then
// frame-gated streaming of the host AXI-stream phase by phase.
//
// Handshake: a beat transfers on a rising clock edge where valid and
// ready are both high. The gate is purely combinational: up_tready
// follows dn_tready and dn_tvalid/dn_tlast follow up_tvalid/up_tlast,
// each only while a stream phase is active; nothing is buffered.
module lpn_session_sequencer
    import lpn_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mode,
    input  logic        global_start,
    input  logic        pok_done,
    output logic        pok_resetn,
    input  logic        fault,
    input  logic        up_tvalid,
    input  logic        up_tlast,
    output logic        up_tready,
    output logic        dn_tvalid,
    output logic        dn_tlast,
    input  logic        dn_tready,
    output logic [2:0]  phase,
    output logic [6:0]  frame_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [3:0]  state_dbg
);

    seq_state_e            state, state_next;
    phase_e                phase_q;
    err_e                  err_code_q, err_code_set;
    logic                  err_q, err_set;
    logic                  start_q, mode_q;
    logic                  start_edge, accept, hs, clear_cnt;
    logic [POK_RST_W-1:0]  rst_cnt;
    logic [POK_TO_W-1:0]   to_cnt;
    logic                  frame_done, phase_done, short_err, long_err;
    logic [FRAME_W-1:0]    limit;

    assign start_edge = global_start & ~start_q;
    assign hs         = up_tvalid & up_tready;
    assign limit      = frame_limit(phase_of(state), mode_q);

    // Stream-phase decode and host/core handshake gating.
    always_comb begin
        accept = 1'b0;
        case (state)
            ST_I, ST_B, ST_AINV, ST_A, ST_HASH: accept = 1'b1;
            default:                            accept = 1'b0;
        endcase
        up_tready = accept & dn_tready;
        dn_tvalid = accept & up_tvalid;
        dn_tlast  = accept & up_tlast;
    end

    frame_counter u_frame_counter (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear_cnt),
        .hs         (hs),
        .last       (up_tlast),
        .limit      (limit),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .phase_done (phase_done),
        .short_err  (short_err),
        .long_err   (long_err)
    );

    // Next state and error capture; fault beats frame errors, which beat
    // phase advance.
    always_comb begin
        state_next   = state;
        err_set      = 1'b0;
        err_code_set = E_NONE;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_next = ST_POK_RST;
            end
            ST_POK_RST: begin
                if (rst_cnt == POK_RST_W'(POK_RST_CYCLES - 1)) state_next = ST_POK_WAIT;
            end
            ST_POK_WAIT: begin
                if (pok_done) begin
                    state_next = mode_q ? ST_I : ST_A;
                end else if (to_cnt == POK_TO_W'(POK_TIMEOUT - 1)) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = E_POK_TO;
                end
            end
            ST_I, ST_B, ST_AINV, ST_A, ST_HASH: begin
                if (short_err) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = E_SHORT;
                end else if (long_err) begin
                    state_next   = ST_ERROR;
                    err_set      = 1'b1;
                    err_code_set = E_LONG;
                end else if (phase_done) begin
                    case (state)
                        ST_I:    state_next = ST_B;
                        ST_B:    state_next = ST_AINV;
                        ST_AINV: state_next = ST_A;
                        ST_A:    state_next = mode_q ? ST_HASH : ST_DONE;
                        default: state_next = ST_DONE;
                    endcase
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!global_start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (fault && (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR)) begin
            state_next   = ST_ERROR;
            err_set      = 1'b1;
            err_code_set = E_FAULT;
        end
        clear_cnt = (state_next != state) && (state_next != ST_ERROR);
    end

    // Session state, start-edge history, latched mode, phase and sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            phase_q    <= PH_IDLE;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
        end else begin
            state   <= state_next;
            start_q <= global_start;
            if ((state == ST_IDLE) && start_edge) begin
                mode_q     <= mode;
                err_q      <= 1'b0;
                err_code_q <= E_NONE;
            end
            if (err_set) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_set;
            end
            if (state_next != ST_ERROR) phase_q <= phase_of(state_next);
        end
    end

    // PoK reset-length and response-timeout timers, each running only in its state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            rst_cnt <= (state == ST_POK_RST)  ? rst_cnt + POK_RST_W'(1) : '0;
            to_cnt  <= (state == ST_POK_WAIT) ? to_cnt + POK_TO_W'(1)   : '0;
        end
    end

    // Status outputs.
    always_comb begin
        pok_resetn = (state != ST_POK_RST);
        busy       = 1'b0;
        case (state)
            ST_POK_RST, ST_POK_WAIT, ST_I, ST_B, ST_AINV, ST_A, ST_HASH: busy = 1'b1;
            default: busy = 1'b0;
        endcase
        done      = (state == ST_DONE);
        phase     = phase_q;
        err       = err_q;
        err_code  = err_code_q;
        state_dbg = state;
    end

endmodule
